// File: rtl/fp32_pkg.sv
// Shared fp32 constants and the accumulator FSM state encoding.
package fp32_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_GET_X   = 3'd0,
    ST_SEND_A  = 3'd1,
    ST_SEND_B  = 3'd2,
    ST_GET_Z   = 3'd3,
    ST_PUT_SUM = 3'd4
  } acc_state_e;

endpackage

// File: rtl/fp32_accumulator_master_if.sv
// Bundles the upstream, adder and downstream stb/ack ports of the accumulator.
// Handshake: a transfer happens on the rising edge where stb and ack are both 1;
// the producer keeps its data stable for as long as its stb is high.
interface fp32_accumulator_master_if #(parameter int COUNT_W = 16);

  logic [31:0]        in_data;
  logic               in_last;
  logic               in_stb;
  logic               in_ack;

  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic               add_a_stb;
  logic               add_b_stb;
  logic               add_a_ack;
  logic               add_b_ack;
  logic [31:0]        add_z;
  logic               add_z_stb;
  logic               add_z_ack;

  logic [31:0]        sum_out;
  logic [COUNT_W-1:0] sum_count;
  logic               sum_stb;
  logic               sum_ack;

  modport master (
    input  in_data, in_last, in_stb,
    output in_ack,
    output add_a, add_b, add_a_stb, add_b_stb,
    input  add_a_ack, add_b_ack,
    input  add_z, add_z_stb,
    output add_z_ack,
    output sum_out, sum_count, sum_stb,
    input  sum_ack
  );

  modport slave (
    output in_data, in_last, in_stb,
    input  in_ack,
    input  add_a, add_b, add_a_stb, add_b_stb,
    output add_a_ack, add_b_ack,
    output add_z, add_z_stb,
    input  add_z_ack,
    input  sum_out, sum_count, sum_stb,
    output sum_ack
  );

endinterface

// File: rtl/fp32_stb_source.sv
// Registered producer port: load raises stb with new data; stb drops on the
// edge where the consumer acks.
module fp32_stb_source #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ack,
  output logic         stb,
  output logic [W-1:0] data
);

  logic         stb_q, stb_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    stb_d  = stb_q;
    data_d = data_q;
    if (stb_q && ack) begin
      stb_d = 1'b0;
    end
    if (load) begin
      stb_d  = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      stb_q  <= stb_d;
      data_q <= data_d;
    end
  end

  assign stb  = stb_q;
  assign data = data_q;

endmodule

// File: rtl/fp32_accumulator_master.sv
// Streams fp32 elements through an external adder, feeding each result back as
// the running sum, and emits one total plus element count per stream.
module fp32_accumulator_master
  import fp32_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  fp32_accumulator_master_if.master  bus,
  output acc_state_e                 dbg_state
);

  acc_state_e         state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        x_q, x_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_ack_q, in_ack_d;
  logic               z_ack_q, z_ack_d;

  logic               a_load, b_load, sum_load;
  logic               a_stb, b_stb, sum_stb;
  logic [31:0]        a_data, b_data;
  logic [COUNT_W+31:0] sum_data;

  logic               in_xfer, a_xfer, b_xfer, z_xfer, sum_xfer;

  assign in_xfer  = in_ack_q && bus.in_stb;
  assign a_xfer   = a_stb && bus.add_a_ack;
  assign b_xfer   = b_stb && bus.add_b_ack;
  assign z_xfer   = z_ack_q && bus.add_z_stb;
  assign sum_xfer = sum_stb && bus.sum_ack;

  // Each handshake output is loaded on the edge that enters its state, so it
  // is already high during the first cycle spent there.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    x_d      = x_q;
    last_d   = last_q;
    count_d  = count_q;
    in_ack_d = in_ack_q;
    z_ack_d  = z_ack_q;
    a_load   = 1'b0;
    b_load   = 1'b0;
    sum_load = 1'b0;
    unique case (state_q)
      ST_GET_X: begin
        in_ack_d = 1'b1;
        if (in_xfer) begin
          x_d      = bus.in_data;
          last_d   = bus.in_last;
          count_d  = (&count_q) ? count_q : count_q + COUNT_W'(1);
          in_ack_d = 1'b0;
          a_load   = 1'b1;
          state_d  = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        if (a_xfer) begin
          b_load  = 1'b1;
          state_d = ST_SEND_B;
        end
      end
      ST_SEND_B: begin
        if (b_xfer) begin
          z_ack_d = 1'b1;
          state_d = ST_GET_Z;
        end
      end
      ST_GET_Z: begin
        if (z_xfer) begin
          acc_d   = bus.add_z;
          z_ack_d = 1'b0;
          if (last_q) begin
            sum_load = 1'b1;
            state_d  = ST_PUT_SUM;
          end else begin
            in_ack_d = 1'b1;
            state_d  = ST_GET_X;
          end
        end
      end
      ST_PUT_SUM: begin
        if (sum_xfer) begin
          acc_d    = FP32_POS_ZERO;
          count_d  = '0;
          in_ack_d = 1'b1;
          state_d  = ST_GET_X;
        end
      end
      default: begin
        state_d = ST_GET_X;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_GET_X;
      acc_q    <= FP32_POS_ZERO;
      x_q      <= '0;
      last_q   <= 1'b0;
      count_q  <= '0;
      in_ack_q <= 1'b0;
      z_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      last_q   <= last_d;
      count_q  <= count_d;
      in_ack_q <= in_ack_d;
      z_ack_q  <= z_ack_d;
    end
  end

  fp32_stb_source #(.W(32)) u_src_a (
    .clk       (clock),
    .rst_n     (reset),
    .load      (a_load),
    .load_data (acc_q),
    .ack       (bus.add_a_ack),
    .stb       (a_stb),
    .data      (a_data)
  );

  fp32_stb_source #(.W(32)) u_src_b (
    .clk       (clock),
    .rst_n     (reset),
    .load      (b_load),
    .load_data (x_q),
    .ack       (bus.add_b_ack),
    .stb       (b_stb),
    .data      (b_data)
  );

  // The total is taken straight from add_z so it appears the cycle after the final result transfer.
  fp32_stb_source #(.W(COUNT_W + 32)) u_src_sum (
    .clk       (clock),
    .rst_n     (reset),
    .load      (sum_load),
    .load_data ({count_q, bus.add_z}),
    .ack       (bus.sum_ack),
    .stb       (sum_stb),
    .data      (sum_data)
  );

  assign bus.in_ack    = in_ack_q;
  assign bus.add_a     = a_data;
  assign bus.add_a_stb = a_stb;
  assign bus.add_b     = b_data;
  assign bus.add_b_stb = b_stb;
  assign bus.add_z_ack = z_ack_q;
  assign bus.sum_out   = sum_data[31:0];
  assign bus.sum_count = sum_data[COUNT_W+31:32];
  assign bus.sum_stb   = sum_stb;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fp32_accumulator_master.sv
// Bench for fp32_accumulator_master: exact-value fp32 adder model, randomized
// partner delays, directed streams and an asynchronous reset mid-transaction.
module tb_fp32_accumulator_master;
  import fp32_pkg::*;

  localparam int COUNT_W = 16;

  logic       clock;
  logic       reset;
  acc_state_e dbg_state;

  fp32_accumulator_master_if #(.COUNT_W(COUNT_W)) bus ();

  fp32_accumulator_master #(.COUNT_W(COUNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit rand_en  = 0;
  bit hold_b   = 0;

  logic [31:0]        stim_q[$];
  logic [31:0]        got_sum[$];
  logic [COUNT_W-1:0] got_cnt[$];
  logic [31:0]        last_op_a, last_op_b;

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    return rand_en ? int'($urandom_range(0, 7)) : 0;
  endfunction

  // ---------------- exact-value fp32 reference ----------------
  // Values used here are multiples of 2^-8 with magnitude below 2^15, so fixed
  // point with 8 fractional bits represents every operand and sum exactly.
  function automatic longint decode(input logic [31:0] f);
    longint m;
    int     sh;
    if (f[30:23] == 8'd0) return 0;
    m  = longint'({1'b1, f[22:0]});
    sh = int'(f[30:23]) - 142;
    if (sh >= 0) m = m <<< sh;
    else         m = m >>> (-sh);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] encode(input longint v);
    longint      mag;
    int          p;
    logic [7:0]  e;
    logic [22:0] m;
    if (v == 0) return 32'h0000_0000;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    e = 8'(p + 119);
    if (p >= 23) m = 23'(mag >> (p - 23));
    else         m = 23'(mag << (23 - p));
    return {(v < 0), e, m};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan) return a | 32'h0040_0000;
    if (b_nan) return b | 32'h0040_0000;
    if (a_inf && b_inf) return (a[31] != b[31]) ? (FP32_QNAN | 32'h8000_0000) : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a == 32'h8000_0000 && b == 32'h8000_0000) return a;
    return encode(decode(a) + decode(b));
  endfunction

  // ---------------- adder responder ----------------
  initial begin
    int          ph, dly;
    bit          z_pend, a_wait, b_wait;
    logic [31:0] op_a, op_b, z, a_prev, b_prev;
    bus.add_a_ack = 1'b0;
    bus.add_b_ack = 1'b0;
    bus.add_z_stb = 1'b0;
    bus.add_z     = '0;
    ph = 0; dly = 0; z_pend = 0; a_wait = 0; b_wait = 0;
    op_a = '0; op_b = '0; z = '0; a_prev = '0; b_prev = '0;
    forever begin
      @(negedge clock);
      bus.add_a_ack = 1'b0;
      bus.add_b_ack = 1'b0;
      if (!reset) begin
        bus.add_z_stb = 1'b0;
        ph = 0; z_pend = 0; a_wait = 0; b_wait = 0; dly = pick();
      end else begin
        if (ph == 0) begin
          if (bus.add_a_stb) begin
            if (a_wait) check("add_a_stable", bus.add_a, a_prev);
            if (dly == 0) begin
              bus.add_a_ack = 1'b1;
              op_a = bus.add_a;
              ph = 1; dly = pick();
            end else dly--;
            a_prev = bus.add_a;
            a_wait = !bus.add_a_ack;
          end else a_wait = 0;
        end else if (ph == 1) begin
          if (bus.add_b_stb) begin
            if (b_wait) check("add_b_stable", bus.add_b, b_prev);
            if (dly == 0 && !hold_b) begin
              bus.add_b_ack = 1'b1;
              op_b = bus.add_b;
              last_op_a = op_a;
              last_op_b = op_b;
              z = fp_add(op_a, op_b);
              ph = 2; dly = pick();
            end else if (dly != 0) dly--;
            b_prev = bus.add_b;
            b_wait = !bus.add_b_ack;
          end else b_wait = 0;
        end else begin
          if (z_pend) begin
            bus.add_z_stb = 1'b0;
            z_pend = 0; ph = 0; dly = pick();
          end else begin
            if (!bus.add_z_stb) begin
              if (dly == 0) begin
                bus.add_z_stb = 1'b1;
                bus.add_z     = z;
              end else dly--;
            end
            if (bus.add_z_stb && bus.add_z_ack) z_pend = 1;
          end
        end
      end
    end
  end

  // ---------------- downstream sink ----------------
  initial begin
    int                  s_dly;
    bit                  s_wait;
    logic [COUNT_W+31:0] s_prev;
    bus.sum_ack = 1'b0;
    s_dly = 0; s_wait = 0; s_prev = '0;
    forever begin
      @(negedge clock);
      bus.sum_ack = 1'b0;
      if (!reset) begin
        s_wait = 0;
      end else if (bus.sum_stb) begin
        if (s_wait) check("sum_stable", {bus.sum_count, bus.sum_out}, s_prev);
        if (s_dly == 0) begin
          bus.sum_ack = 1'b1;
          got_sum.push_back(bus.sum_out);
          got_cnt.push_back(bus.sum_count);
          s_dly = pick();
        end else s_dly--;
        s_prev = {bus.sum_count, bus.sum_out};
        s_wait = !bus.sum_ack;
      end else s_wait = 0;
    end
  end

  // ---------------- upstream driver ----------------
  task automatic send_elem(input logic [31:0] d, input logic l);
    int n;
    if (rand_en) repeat ($urandom_range(0, 3)) @(negedge clock);
    bus.in_data = d;
    bus.in_last = l;
    bus.in_stb  = 1'b1;
    n = 0;
    while (!bus.in_ack && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) check("in_ack_timeout", 64'(bus.in_ack), 64'd1);
    @(negedge clock);
    bus.in_stb  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic send_stream();
    for (int i = 0; i < stim_q.size(); i++) send_elem(stim_q[i], i == stim_q.size() - 1);
    stim_q.delete();
  endtask

  task automatic expect_total(input string tag, input logic [31:0] exp_sum, input logic [COUNT_W-1:0] exp_cnt);
    int n;
    n = 0;
    while (got_sum.size() == 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (got_sum.size() == 0) begin
      check({tag, "_timeout"}, 64'(got_sum.size()), 64'd1);
    end else begin
      check({tag, "_sum"}, 64'(got_sum.pop_front()), 64'(exp_sum));
      check({tag, "_count"}, 64'(got_cnt.pop_front()), 64'(exp_cnt));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int     n, len, remaining, k;
    longint fx_sum;
    logic [31:0] v;
    reset       = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_stb  = 1'b0;
    last_op_a   = '0;
    last_op_b   = '0;
    repeat (2) @(negedge clock);

    check("rst_in_ack", 64'(bus.in_ack), 64'd0);
    check("rst_stbs", 64'({bus.add_a_stb, bus.add_b_stb, bus.add_z_ack, bus.sum_stb}), 64'd0);
    check("rst_data", 64'({bus.add_a, bus.add_b, bus.sum_out, bus.sum_count}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_GET_X));
    reset = 1'b1;
    #1 check("rel_in_ack_low", 64'(bus.in_ack), 64'd0);
    @(negedge clock);
    check("rel_in_ack_first_edge", 64'(bus.in_ack), 64'd1);

    // 1 + 2 + 3
    stim_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    send_stream();
    expect_total("t_123", 32'h40C0_0000, 3);
    repeat (10) @(negedge clock);
    check("t_123_one_pulse", 64'(got_sum.size()), 64'd0);

    // single negative element passes through the adder as 0 + x
    stim_q = '{32'hBF80_0000};
    send_stream();
    expect_total("t_single", 32'hBF80_0000, 1);
    check("t_single_op_a", 64'(last_op_a), 64'h0000_0000);
    check("t_single_op_b", 64'(last_op_b), 64'hBF80_0000);

    // back-to-back streams
    stim_q = '{32'h3F80_0000, 32'h3F80_0000};
    send_stream();
    stim_q = '{32'h3F00_0000};
    send_stream();
    expect_total("t_b2b_first", 32'h4000_0000, 2);
    expect_total("t_b2b_second", 32'h3F00_0000, 1);

    // reset while add_b_stb is high
    hold_b = 1;
    stim_q = '{32'h3F80_0000};
    send_stream();
    n = 0;
    while (!bus.add_b_stb && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("rst_mid_b_stb_seen", 64'(bus.add_b_stb), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_handshakes", 64'({bus.in_ack, bus.add_a_stb, bus.add_b_stb, bus.add_z_ack, bus.sum_stb}), 64'd0);
    check("rst_mid_data", 64'({bus.add_a, bus.add_b, bus.sum_out, bus.sum_count}), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(ST_GET_X));
    repeat (2) @(negedge clock);
    hold_b = 0;
    reset  = 1'b1;
    @(negedge clock);
    check("rst_mid_in_ack_back", 64'(bus.in_ack), 64'd1);
    stim_q = '{32'h4000_0000};
    send_stream();
    expect_total("t_after_rst", 32'h4000_0000, 1);
    check("t_after_rst_no_extra", 64'(got_sum.size()), 64'd0);

    // inf + -inf: the adder's NaN is passed through unmodified
    stim_q = '{32'h7F80_0000, 32'hFF80_0000};
    send_stream();
    expect_total("t_nan", 32'hFFC0_0000, 2);

    // random values, random stream lengths, random partner delays
    rand_en   = 1;
    remaining = 200;
    while (remaining > 0) begin
      len = int'($urandom_range(1, 10));
      if (len > remaining) len = remaining;
      fx_sum = 0;
      for (int i = 0; i < len; i++) begin
        k = int'($urandom_range(0, 4000)) - 2000;
        v = encode(longint'(k) * 16);
        fx_sum += longint'(k) * 16;
        stim_q.push_back(v);
      end
      send_stream();
      expect_total("t_rand", encode(fx_sum), COUNT_W'(len));
      remaining -= len;
    end
    rand_en = 0;
    repeat (20) @(negedge clock);
    check("t_rand_no_extra", 64'(got_sum.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
